id_hazard_ctrl: RTL and testbench



---
 rtl/id_hazard_ctrl_pkg.sv | 17 +
 rtl/id_scoreboard.sv | 61 ++++++
 rtl/id_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared types and defaults for the decode hazard controller
package id_hazard_ctrl_pkg;

  typedef enum logic {
    HZ_STATE_RUN   = 1'b0,
    HZ_STATE_FLUSH = 1'b1
  } hz_state_e;

  localparam int PEND_W_DEFAULT = 2;
  localparam int FLUSH_CNT_W    = 3;

  // Counter reload value; the cycle the branch resolves is the first flush cycle.
  function automatic logic [FLUSH_CNT_W-1:0] flush_cnt_init(input int flush_cycles);
    return FLUSH_CNT_W'(flush_cycles - 1);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register pending-write counters for decode hazard detection
module id_scoreboard
  import id_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = PEND_W_DEFAULT,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_rd,
  input  logic             dec_en,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] rd_idx1,
  input  logic [REG_W-1:0] rd_idx2,
  input  logic [REG_W-1:0] rd_idx_dst,
  output logic             busy1,
  output logic             busy2,
  output logic             last1,
  output logic             last2,
  output logic             full_rd
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];

  // Simultaneous inc and dec of one register cancel; a dec at zero holds at zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r == 0) begin
        pend_d[r] = '0;
      end else if (inc_en && inc_rd == REG_W'(r) && !(dec_en && dec_rd == REG_W'(r))) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec_en && dec_rd == REG_W'(r) && !(inc_en && inc_rd == REG_W'(r))
                   && pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_q[r] <= rst ? '0 : pend_d[r];
    end
  end

  assign busy1   = pend_q[rd_idx1] != '0;
  assign busy2   = pend_q[rd_idx2] != '0;
  assign last1   = pend_q[rd_idx1] == PEND_ONE;
  assign last2   = pend_q[rd_idx2] == PEND_ONE;
  assign full_rd = pend_q[rd_idx_dst] == PEND_MAX;

  dec_at_zero: assert property (@(posedge clk) disable iff (rst)
    dec_en |-> (pend_q[dec_rd] != '0));

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - decode-stage stall/flush controller driven by a write scoreboard
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int PEND_W       = PEND_W_DEFAULT,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_W        = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_used,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_write,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             issue,
  output logic [31:0]      stall_count
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = flush_cnt_init(FLUSH_CYCLES);

  logic busy1, busy2, last1, last2, full_rd;
  logic raw1, raw2, ovf, hazard, flush_raw;
  logic inc_en, dec_en;
  hz_state_e state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] stall_count_q;

  id_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W),
    .REG_W    (REG_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .inc_en     (inc_en),
    .inc_rd     (id_rd),
    .dec_en     (dec_en),
    .dec_rd     (wb_rd),
    .rd_idx1    (id_rs1),
    .rd_idx2    (id_rs2),
    .rd_idx_dst (id_rd),
    .busy1      (busy1),
    .busy2      (busy2),
    .last1      (last1),
    .last2      (last2),
    .full_rd    (full_rd)
  );

  // A last writer retiring this cycle is forwarded, so it does not stall.
  assign raw1 = id_rs1_used && id_rs1 != '0 && busy1 && !(wb_valid && wb_rd == id_rs1 && last1);
  assign raw2 = id_rs2_used && id_rs2 != '0 && busy2 && !(wb_valid && wb_rd == id_rs2 && last2);
  assign ovf  = id_rd_write && id_rd != '0 && full_rd && !(wb_valid && wb_rd == id_rd);
  assign hazard = id_valid && (raw1 || raw2 || ovf);

  assign flush_raw   = ex_branch_taken || state_q == HZ_STATE_FLUSH;
  assign flush_if_id = !rst && flush_raw;
  assign stall_id    = !rst && hazard && !flush_raw;
  assign stall_if    = stall_id;
  assign bubble_ex   = stall_id || flush_if_id;
  assign issue       = !rst && id_valid && !hazard && !flush_raw;
  assign stall_count = stall_count_q;

  assign inc_en = issue && id_rd_write && id_rd != '0;
  assign dec_en = wb_valid && wb_rd != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_STATE_RUN: begin
        if (ex_branch_taken) begin
          state_d = HZ_STATE_FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      HZ_STATE_FLUSH: begin
        if (ex_branch_taken) begin
          cnt_d = CNT_INIT;
        end else if (cnt_q == '0) begin
          state_d = HZ_STATE_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = HZ_STATE_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HZ_STATE_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_q + {31'd0, stall_id};
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - randomized and directed checks of id_hazard_ctrl against a reference model
module tb_id_hazard_ctrl;

  localparam int NREG = 32;
  localparam int PW   = 2;
  localparam int FC   = 2;
  localparam int PEND_MAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_write, wb_valid, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic stall_if, stall_id, bubble_ex, flush_if_id, issue;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  int pend [NREG];
  int flush_rem = 0;
  int unsigned m_count = 0;
  bit e_flush, e_stall, e_issue, e_bubble;

  always #5 clk = ~clk;

  id_hazard_ctrl #(
    .NUM_REGS     (NREG),
    .PEND_W       (PW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs1_used     (id_rs1_used),
    .id_rs2          (id_rs2),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_rd_write     (id_rd_write),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .ex_branch_taken (ex_branch_taken),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .flush_if_id     (flush_if_id),
    .issue           (issue),
    .stall_count     (stall_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_eval();
    bit r1, r2, ov, hz, fl;
    r1 = id_rs1_used && id_rs1 != 0 && pend[id_rs1] != 0
         && !(wb_valid && wb_rd == id_rs1 && pend[id_rs1] == 1);
    r2 = id_rs2_used && id_rs2 != 0 && pend[id_rs2] != 0
         && !(wb_valid && wb_rd == id_rs2 && pend[id_rs2] == 1);
    ov = id_rd_write && id_rd != 0 && pend[id_rd] == PEND_MAX && !(wb_valid && wb_rd == id_rd);
    hz = id_valid && (r1 || r2 || ov);
    fl = ex_branch_taken || flush_rem > 0;
    if (rst) begin
      e_flush = 0; e_stall = 0; e_issue = 0;
    end else begin
      e_flush = fl; e_stall = hz && !fl; e_issue = id_valid && !hz && !fl;
    end
    e_bubble = e_stall || e_flush;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (pend[i]) pend[i] = 0;
      flush_rem = 0;
      m_count = 0;
    end else begin
      model_eval();
      if (e_stall) m_count++;
      if (e_issue && id_rd_write && id_rd != 0) pend[id_rd]++;
      if (wb_valid && wb_rd != 0 && pend[wb_rd] > 0) pend[wb_rd]--;
      if (ex_branch_taken) flush_rem = FC;
      else if (flush_rem > 0) flush_rem--;
    end
  end

  always @(negedge clk) begin
    model_eval();
    chk("stall_id", {31'd0, stall_id}, {31'd0, e_stall});
    chk("stall_if", {31'd0, stall_if}, {31'd0, e_stall});
    chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bubble});
    chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_flush});
    chk("issue", {31'd0, issue}, {31'd0, e_issue});
    chk("stall_count", stall_count, m_count);
  end

  task automatic drive_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                          input int d, input bit w);
    id_valid = v; id_rs1 = 5'(s1); id_rs1_used = u1; id_rs2 = 5'(s2); id_rs2_used = u2;
    id_rd = 5'(d); id_rd_write = w;
  endtask

  task automatic drive_wb(input bit v, input int r);
    wb_valid = v; wb_rd = 5'(r);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input string nm, input bit st, input bit fl, input bit is);
    chk({nm, ".stall_id"}, {31'd0, stall_id}, {31'd0, st});
    chk({nm, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fl});
    chk({nm, ".issue"}, {31'd0, issue}, {31'd0, is});
    chk({nm, ".bubble_ex"}, {31'd0, bubble_ex}, {31'd0, st || fl});
  endtask

  initial begin
    rst = 1'b1;
    drive_id(1, 5, 1, 6, 1, 5, 1);
    drive_wb(0, 0);
    ex_branch_taken = 1'b1;
    settle(); exp_ctl("reset", 0, 0, 0); chk("reset.stall_count", stall_count, 32'd0);
    tick(); tick();
    rst = 1'b0; ex_branch_taken = 1'b0;

    // back-to-back dependency on r5
    drive_id(1, 0, 0, 0, 0, 5, 1); settle(); exp_ctl("b2b_w", 0, 0, 1); tick();
    drive_id(1, 5, 1, 0, 0, 0, 0); settle(); exp_ctl("b2b_s1", 1, 0, 0); tick();
    settle(); exp_ctl("b2b_s2", 1, 0, 0); tick();
    drive_wb(1, 5); settle(); exp_ctl("b2b_ret", 0, 0, 1);
    chk("b2b.stall_count", stall_count, 32'd2); tick();
    drive_wb(0, 0);

    // bypass on retire of r7
    drive_id(1, 0, 0, 0, 0, 7, 1); settle(); exp_ctl("byp_w", 0, 0, 1); tick();
    drive_id(1, 0, 0, 7, 1, 0, 0); drive_wb(1, 7); settle(); exp_ctl("byp_r", 0, 0, 1); tick();
    drive_wb(0, 0); settle(); exp_ctl("byp_after", 0, 0, 1); tick();

    // r0 never tracked
    for (int i = 0; i < 4; i++) begin
      drive_id(1, 0, 1, 0, 1, 0, 1); settle(); exp_ctl("r0", 0, 0, 1); tick();
    end

    // overflow on r3
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 0, 0, 0, 0, 3, 1); settle(); exp_ctl("ovf_fill", 0, 0, 1); tick();
    end
    settle(); exp_ctl("ovf_full", 1, 0, 0); tick();
    drive_wb(1, 3); settle(); exp_ctl("ovf_wb", 0, 0, 1); tick();
    drive_wb(0, 0); settle(); exp_ctl("ovf_still", 1, 0, 0); tick();
    drive_id(1, 3, 0, 3, 0, 0, 0); settle(); exp_ctl("unused_src", 0, 0, 1); tick();

    // branch flush priority and extension
    drive_id(1, 0, 0, 0, 0, 9, 1); settle(); exp_ctl("br_w", 0, 0, 1); tick();
    drive_id(1, 9, 1, 0, 0, 0, 0); ex_branch_taken = 1'b1;
    settle(); exp_ctl("br0", 0, 1, 0); tick();
    ex_branch_taken = 1'b0; settle(); exp_ctl("br1", 0, 1, 0); tick();
    ex_branch_taken = 1'b1; settle(); exp_ctl("br2", 0, 1, 0); tick();
    ex_branch_taken = 1'b0; settle(); exp_ctl("br3", 0, 1, 0); tick();
    settle(); exp_ctl("br4", 0, 1, 0); tick();
    settle(); exp_ctl("br5", 1, 0, 0); tick();

    // reset mid-stall with pending[9]=2
    drive_id(1, 0, 0, 0, 0, 9, 1); settle(); exp_ctl("rs_w", 0, 0, 1); tick();
    drive_id(1, 9, 1, 0, 0, 0, 0); settle(); exp_ctl("rs_stall", 1, 0, 0); tick();
    rst = 1'b1; settle(); exp_ctl("rs_in", 0, 0, 0); tick();
    rst = 1'b0; settle(); exp_ctl("rs_out", 0, 0, 1);
    chk("rs.stall_count", stall_count, 32'd0); tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 2) != 0);
      r = $urandom_range(0, 7);
      drive_wb(($urandom_range(0, 9) < 4) && (r == 0 || pend[r] > 0), r);
      ex_branch_taken = ($urandom_range(0, 19) == 0);
      tick();
    end

    rst = 1'b0; drive_id(0, 0, 0, 0, 0, 0, 0); drive_wb(0, 0); ex_branch_taken = 1'b0;
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
